ysyx_25050147_imem_responder: RTL
=================================

Name: ysyx_25050147_imem_responder

Overview:
Instruction-memory responder serving the core's fetch side. The core issues a PC over a valid/ready request channel. This block returns the 32-bit instruction word over a valid/ready response channel after a programmable latency. A side load port lets the testbench or loader preload program images. Simulation and FPGA memory model for the multi-cycle NPC fetch path.

Parameters:
DEPTH, 4096, number of 32-bit words stored (power of 2)
BASE, 32'h80000000, byte address mapped to word 0
LATENCY, 2, cycles from request acceptance to rsp_valid (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address (PC) of requested instruction
rsp_valid  output  1  response valid
rsp_ready  input  1  core accepts response
rsp_data  output  32  instruction word; 0 when rsp_err=1
rsp_err  output  1  access fault: misaligned or out of range
ld_en  input  1  load-port write enable
ld_addr  input  32  load byte address (same map as req_addr)
ld_data  input  32  load data word

Behaviour:
- Reset (rst=0, asynchronous assert; release synchronous to clk): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, latency counter=0. Memory array is not cleared.
- Reset asserted mid-transaction aborts the pending request. No response is ever produced for it.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready at an edge, the request is accepted.
    - Capture the error flag and the word.
    - Load counter with LATENCY-1.
    - Go to WAIT, or to RESP directly if LATENCY=1.
  - WAIT: req_ready=0. Decrement counter each cycle. When the counter is 1, go to RESP next edge.
  - RESP: rsp_valid=1, data/err stable. On rsp_valid&rsp_ready go to IDLE. Hold indefinitely while rsp_ready=0.
- Latency: request accepted at edge T gives rsp_valid high in the cycle following edge T+LATENCY-1. With LATENCY=1, rsp_valid is high the cycle right after acceptance.
- Single outstanding request. req_ready is 0 in WAIT and RESP, including the cycle of response handshake; next accept is earliest one cycle after return to IDLE.
- Address decode:
  - offset = req_addr - BASE (32-bit wrap arithmetic); index = offset[31:2].
  - Error if req_addr[1:0]!=0, or req_addr<BASE, or index>=DEPTH.
  - On error: rsp_err=1, rsp_data=0. Latency is still LATENCY; the memory is not read.
- Data snapshot: word is read at the acceptance edge and held in a register. Later load writes do not change an in-flight response.
- Load port:
  - Independent of the FSM; writes on any edge with ld_en=1 and an in-range, aligned ld_addr. Other addresses are silently ignored.
  - Same-edge ld_en and request acceptance to the same word: response returns the OLD contents (read-before-write).
- rsp_data/rsp_err change only on acceptance edge or reset; values are undefined-free (registered) outside RESP but not meaningful.

Test Plan:
- Reset then idle: hold rst=0 with clk running -> req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0. Release rst=1 -> req_ready=1.
- Basic fetch, LATENCY=2: preload 0x80000000<=0x00100073 via load port; req 0x80000000 accepted at edge T -> rsp_valid=1 in cycle after T+1, rsp_data=0x00100073, rsp_err=0. rsp_ready=1 -> req_ready=1 next cycle.
- Backpressure: preload 0x80000004<=0x00000013; request it; hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_data stays 0x00000013, req_ready stays 0, a second req_valid is ignored.
- Faults: req 0x80000002 -> rsp_err=1, rsp_data=0 after LATENCY. req 0x7FFFFFFC -> rsp_err=1. req BASE+4*DEPTH -> rsp_err=1.
- Read/write collision: word 0x80000010 holds 0xAAAAAAAA; same edge ld_en writes 0x55555555 and request to 0x80000010 is accepted -> rsp_data=0xAAAAAAAA. Next request to the same address -> 0x55555555.
- Reset mid-operation: accept request, drop rst=0 during WAIT -> rsp_valid=0 immediately, state IDLE after release, no response for the aborted request. A fresh request completes normally.

Source files
------------

// File: rtl/ysyx_25050147_imem_responder.sv
// Instruction-memory responder for the NPC fetch path: accepts one PC at a time and
// returns the stored word (or an access fault) after a fixed, parameterised latency.
module ysyx_25050147_imem_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  // BASE is word-aligned, so the word offset is just the difference of the word parts.
  logic [29:0]   req_off, ld_off;
  logic          req_hit, ld_hit;
  logic [AW-1:0] req_idx, ld_idx;
  logic          accept;

  always_comb begin
    req_off = req_addr[31:2] - BASE[31:2];
    req_hit = (req_addr[1:0] == 2'b00) && (req_addr >= BASE) && ({2'b00, req_off} < DEPTH);
    req_idx = req_off[AW-1:0];
    ld_off  = ld_addr[31:2] - BASE[31:2];
    ld_hit  = (ld_addr[1:0] == 2'b00) && (ld_addr >= BASE) && ({2'b00, ld_off} < DEPTH);
    ld_idx  = ld_off[AW-1:0];
  end

  assign accept = req_valid && req_ready;

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word is snapshotted at acceptance; faulting requests never touch the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q  <= !req_hit;
        data_q <= req_hit ? mem[req_idx] : 32'h0;
      end
    end
  end

  // NOTE: the array carries no reset, and the non-blocking write means a read on the
  // same edge sees the old word.
  always_ff @(posedge clk) begin
    if (ld_en && ld_hit) mem[ld_idx] <= ld_data;
  end

  assign rsp_data = data_q;
  assign rsp_err  = err_q;

endmodule
